// File: rtl/gray_pkg.sv
// ============================================================================
// gray_pkg : shared constants for the Gray-to-binary pipeline
// Revision : 1.0
// ============================================================================
`default_nettype none

package gray_pkg;

   localparam int DEFAULT_WIDTH = 4;

   localparam logic [1:0] DIR_HOLD = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

endpackage

`default_nettype wire

// File: rtl/gray2bin_comb.sv
// ============================================================================
// gray2bin_comb : combinational Gray-to-binary decoder
// Revision      : 1.0
// ============================================================================
`default_nettype none

module gray2bin_comb
   import gray_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   // bin[i] is the XOR of every Gray bit at or above position i
   always_comb begin
      bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
         bin[i] = ^(gray >> i);
      end
   end

endmodule

`default_nettype wire

// File: rtl/gray_to_bin_pipe.sv
// ============================================================================
// gray_to_bin_pipe : 2-stage Gray decoder with step direction and error check
//                    (step checker compiled in with GRAY_STEP_CHECK_EN)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module gray_to_bin_pipe
   import gray_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_gray,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_bin,
   output logic [1:0]       out_dir,
   output logic             out_err,
   output logic [7:0]       err_cnt
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_gray_q,  s1_gray_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] out_bin_q,  out_bin_d;
   logic [1:0]       out_dir_q,  out_dir_d;
   logic             out_err_q,  out_err_d;
   logic [WIDTH-1:0] prev_bin_q, prev_bin_d;
   logic             have_prev_q, have_prev_d;

   logic             s1_adv;
   logic             accept;
   logic             move;
   logic [WIDTH-1:0] dec_bin;
   logic [1:0]       dir;
   logic             step_err;

   assign s1_adv   = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s1_adv;
   assign accept   = in_valid && in_ready;
   assign move     = s1_valid_q && s1_adv;

   gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
      .gray (s1_gray_q),
      .bin  (dec_bin)
   );

   // Modular compare makes all-ones -> zero an up step and zero -> all-ones down
   always_comb begin
      dir = DIR_HOLD;
      if (have_prev_q) begin
         if (dec_bin == prev_bin_q + ONE) begin
            dir = DIR_UP;
         end else if (dec_bin == prev_bin_q - ONE) begin
            dir = DIR_DOWN;
         end
      end
   end

`ifdef GRAY_STEP_CHECK_EN
   logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
   logic [7:0]       err_cnt_q,   err_cnt_d;
   logic [WIDTH-1:0] gray_diff;

   // More than one changed bit <=> clearing the lowest set bit leaves a residue
   assign gray_diff = s1_gray_q ^ prev_gray_q;
   assign step_err  = have_prev_q && (|(gray_diff & (gray_diff - ONE)));
   assign err_cnt   = err_cnt_q;

   always_comb begin
      prev_gray_d = prev_gray_q;
      err_cnt_d   = err_cnt_q;
      if (move) begin
         prev_gray_d = s1_gray_q;
         if (step_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_gray_q <= '0;
         err_cnt_q   <= 8'd0;
      end else begin
         prev_gray_q <= prev_gray_d;
         err_cnt_q   <= err_cnt_d;
      end
   end
`else
   assign step_err = 1'b0;
   assign err_cnt  = 8'd0;
`endif

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_gray_d   = s1_gray_q;
      s2_valid_d  = s2_valid_q;
      out_bin_d   = out_bin_q;
      out_dir_d   = out_dir_q;
      out_err_d   = out_err_q;
      prev_bin_d  = prev_bin_q;
      have_prev_d = have_prev_q;

      if (accept) begin
         s1_valid_d = 1'b1;
         s1_gray_d  = in_gray;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s1_adv) begin
         s2_valid_d = s1_valid_q;
      end

      if (move) begin
         out_bin_d   = dec_bin;
         out_dir_d   = dir;
         out_err_d   = step_err;
         prev_bin_d  = dec_bin;
         have_prev_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_gray_q   <= '0;
         s2_valid_q  <= 1'b0;
         out_bin_q   <= '0;
         out_dir_q   <= DIR_HOLD;
         out_err_q   <= 1'b0;
         prev_bin_q  <= '0;
         have_prev_q <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_gray_q   <= s1_gray_d;
         s2_valid_q  <= s2_valid_d;
         out_bin_q   <= out_bin_d;
         out_dir_q   <= out_dir_d;
         out_err_q   <= out_err_d;
         prev_bin_q  <= prev_bin_d;
         have_prev_q <= have_prev_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_bin   = out_bin_q;
   assign out_dir   = out_dir_q;
   assign out_err   = out_err_q;

endmodule

`default_nettype wire

// File: doc/gray_to_bin_pipe.md
GRAY_TO_BIN_PIPE -- requirements
Module: gray_to_bin_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the bit width of the code word (legal range 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning a Gray word is offered.
REQ-005 SHALL have port in_gray, input, WIDTH, the Gray-coded word.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts this cycle.
REQ-007 SHALL have port out_valid, output, 1, meaning a result is presented.
REQ-008 SHALL have port out_ready, input, 1, meaning downstream accepts.
REQ-009 SHALL have port out_bin, output, WIDTH, the decoded binary value.
REQ-010 SHALL have port out_dir, output, 2, the step direction: 01 up, 10 down, 00 hold/none.
REQ-011 SHALL have port out_err, output, 1, the step-error flag aligned with out_bin.
REQ-012 SHALL have port err_cnt, output, 8, the saturating count of step errors.

Function
REQ-013 SHALL decode with bin[WIDTH-1] = g[WIDTH-1] and bin[i] = bin[i+1] XOR g[i], from MSB down.
REQ-014 SHALL be a 2-stage pipeline: S1 registers the accepted Gray word; S2 registers bin, dir and err.
REQ-015 SHALL transfer on in_valid&&in_ready (input side) and out_valid&&out_ready (output side).
REQ-016 SHALL have latency 2: a word accepted at edge N appears on out_* after edge N+1; with out_ready held high, throughput is 1 word per cycle.
REQ-017 SHALL drive S1 advance = !S2_valid || out_ready, and in_ready = !S1_valid || S1 advance (combinational; no dependence on in_valid).
REQ-018 SHALL hold out_bin, out_dir and out_err stable while out_valid && !out_ready.
REQ-019 SHALL derive dir by comparing the decoded value against the previously decoded value, modulo 2^WIDTH: prev+1 gives up, prev-1 gives down; otherwise 00.
REQ-020 SHALL treat wrap-around as a legal step: all-ones to zero is up; zero to all-ones is down.
REQ-021 SHALL give the first word after reset out_dir=00 and out_err=0, with no previous value to compare against.
REQ-022 SHALL update the previous-value register only when a word moves from S1 to S2.

Reset
REQ-023 SHALL, on rst asserted, immediately clear: S1/S2 valid, out_valid=0, out_bin=0, out_dir=00, out_err=0, err_cnt=0, and the previous-value register and first-word flag.
REQ-024 SHALL drop any in-flight words on reset mid-operation, producing no output for them; after deassertion the next word is treated as the first word.
REQ-025 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-026 SHALL provide macro GRAY_STEP_CHECK_EN to compile the step checker in or out.
REQ-027 SHALL, when GRAY_STEP_CHECK_EN is defined, set out_err=1 when popcount(gray XOR prev_gray) > 1; an identical word gives err=0 and dir=00.
REQ-028 SHALL, when GRAY_STEP_CHECK_EN is defined, increment err_cnt by one per errored word at the S1-to-S2 transfer, saturating at 255.
REQ-029 SHALL, when GRAY_STEP_CHECK_EN is undefined, tie out_err to 0 and err_cnt to 0, and remove prev_gray storage; decode and dir are unchanged.

Structure
REQ-030 SHALL place in shared package gray_pkg: direction constants DIR_HOLD=00, DIR_UP=01, DIR_DOWN=10, and the default WIDTH constant.
REQ-031 SHALL use one sub-module, gray2bin_comb (combinational, parameter WIDTH), for the REQ-013 decode, instantiated between S1 and S2.

Verification
REQ-032 SHALL cover: gray 0000,0001,0011,0010 with out_ready=1 -> bin 0,1,2,3; dir 00,01,01,01; each result 2 cycles after its accept.
REQ-033 SHALL cover: gray 1000 followed by 0000 -> bin 15 then 0, dir 01 (wrap up); then 1000 -> bin 15, dir 10.
REQ-034 SHALL cover, with the macro defined: 0000 then 0011 -> out_err=1, dir=00, err_cnt=1; 300 such errors -> err_cnt=255.
REQ-035 SHALL cover: out_ready=0 for 5 cycles while 3 words are offered -> 2 words accepted, in_ready=0, outputs stable; on release, words emerge in order with none lost.
REQ-036 SHALL cover: rst pulse with 2 words in flight -> out_valid=0 at once; next word 0101 -> bin 0110, dir 00, err 0.
REQ-037 SHALL cover, with the macro undefined: 0000 then 0011 -> out_err=0, err_cnt=0, out_bin=2.
